// File: rtl/switchbox_config_loader_pkg.sv
// rtl/switchbox_config_loader_pkg.sv - shared states, default widths and sizing helpers for the switch box config loader
package switchbox_config_loader_pkg;

    localparam int SB_CONFIG_WIDTH   = 112;
    localparam int CONFIG_WORD_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } loader_state_t;

    function automatic int num_words(input int config_width, input int word_width);
        return (config_width + word_width - 1) / word_width;
    endfunction

    // A single-word frame still needs a one-bit counter.
    function automatic int count_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/config_shadow_register.sv
// rtl/config_shadow_register.sv - word-addressed shadow frame plus the committed copy driven to the switch box
module config_shadow_register
    import switchbox_config_loader_pkg::*;
#(
    parameter int CONFIG_WIDTH = SB_CONFIG_WIDTH,
    parameter int WORD_WIDTH   = CONFIG_WORD_WIDTH,
    parameter int COUNT_WIDTH  = count_width(num_words(CONFIG_WIDTH, WORD_WIDTH))
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    write_en,
    input  logic [COUNT_WIDTH-1:0]  write_index,
    input  logic [WORD_WIDTH-1:0]   write_word,
    input  logic                    commit,
    output logic [CONFIG_WIDTH-1:0] config_out
);

    logic [CONFIG_WIDTH-1:0] shadow;

    // Bits of the last word that fall beyond CONFIG_WIDTH simply have no home.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow <= '0;
        end else if (write_en) begin
            for (int b = 0; b < CONFIG_WIDTH; b++) begin
                if (int'(write_index) == (b / WORD_WIDTH)) begin
                    shadow[b] <= write_word[b % WORD_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            config_out <= '0;
        end else if (commit) begin
            config_out <= shadow;
        end
    end

endmodule

// File: rtl/switchbox_config_loader.sv
// rtl/switchbox_config_loader.sv - loads a bitstream frame word by word and commits it to a switch box
module switchbox_config_loader
    import switchbox_config_loader_pkg::*;
#(
    parameter int CONFIG_WIDTH = SB_CONFIG_WIDTH,
    parameter int WORD_WIDTH   = CONFIG_WORD_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WORD_WIDTH-1:0]   word_in,
    input  logic                    word_valid,
    output logic                    word_ready,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    config_loaded,
    output logic                    busy,
    output logic                    done
);

    localparam int NUM_WORDS   = num_words(CONFIG_WIDTH, WORD_WIDTH);
    localparam int COUNT_WIDTH = count_width(NUM_WORDS);
    localparam logic [COUNT_WIDTH-1:0] LAST_INDEX = COUNT_WIDTH'(NUM_WORDS - 1);

    loader_state_t          state, state_next;
    logic [COUNT_WIDTH-1:0] count, count_next;
    logic                   transfer;
    logic                   commit_now;
    logic                   done_q;
    logic                   loaded_q;

    // Handshake and status come straight from state so inputs never reach outputs combinationally.
    assign word_ready    = (state == LOAD);
    assign busy          = (state != IDLE);
    assign transfer      = word_ready && word_valid;
    assign commit_now    = (state == COMMIT);
    assign done          = done_q;
    assign config_loaded = loaded_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    count_next = '0;
                end
            end
            LOAD: begin
                if (transfer) begin
                    if (count == LAST_INDEX) begin
                        state_next = COMMIT;
                    end else begin
                        count_next = count + COUNT_WIDTH'(1);
                    end
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_q   <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            done_q <= commit_now;
            if (commit_now) begin
                loaded_q <= 1'b1;
            end
        end
    end

    config_shadow_register #(
        .CONFIG_WIDTH (CONFIG_WIDTH),
        .WORD_WIDTH   (WORD_WIDTH),
        .COUNT_WIDTH  (COUNT_WIDTH)
    ) u_shadow (
        .clock       (clock),
        .reset       (reset),
        .write_en    (transfer),
        .write_index (count),
        .write_word  (word_in),
        .commit      (commit_now),
        .config_out  (config_out)
    );

endmodule

// File: tb/tb_switchbox_config_loader.sv
// tb/tb_switchbox_config_loader.sv - directed self-checking bench for switchbox_config_loader
module tb_switchbox_config_loader;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   word_in = 8'h00;
    logic         word_valid = 1'b0;
    logic         word_ready;
    logic [111:0] config_out;
    logic         config_loaded;
    logic         busy;
    logic         done;

    logic         s_start = 1'b0;
    logic [7:0]   s_word_in = 8'h00;
    logic         s_word_valid = 1'b0;
    logic         s_word_ready;
    logic [19:0]  s_config_out;
    logic         s_config_loaded;
    logic         s_busy;
    logic         s_done;

    logic [7:0]   frame_words [14];
    int           vectors = 0;
    int           miscompares = 0;
    int           dc;
    bit           lk;

    always #5 clock = ~clock;

    switchbox_config_loader dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .word_in       (word_in),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .config_out    (config_out),
        .config_loaded (config_loaded),
        .busy          (busy),
        .done          (done)
    );

    switchbox_config_loader #(
        .CONFIG_WIDTH (20),
        .WORD_WIDTH   (8)
    ) dut_small (
        .clock         (clock),
        .reset         (reset),
        .start         (s_start),
        .word_in       (s_word_in),
        .word_valid    (s_word_valid),
        .word_ready    (s_word_ready),
        .config_out    (s_config_out),
        .config_loaded (s_config_loaded),
        .busy          (s_busy),
        .done          (s_done)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [111:0] frame_image();
        logic [111:0] img;
        img = '0;
        for (int k = 0; k < 14; k++) img[k*8 +: 8] = frame_words[k];
        return img;
    endfunction

    // Cycle 0 is the cycle start is high; returns the cycle in which done is seen (-1 on timeout).
    task automatic load_frame(input bit gappy, input int restart_at, input bit valid_after,
                              output int done_cycle, output bit leaked);
        logic [111:0] old_cfg;
        int  k;
        bit  ready_s;
        old_cfg    = config_out;
        leaked     = 1'b0;
        done_cycle = -1;
        k          = 0;
        start      = 1'b1;
        word_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            if (done) begin
                done_cycle = cyc;
                break;
            end
            if (config_out !== old_cfg) leaked = 1'b1;
            start = (restart_at >= 0) && (k == restart_at);
            if (k < 14) begin
                word_valid = !gappy || (cyc % 2 == 1);
                word_in    = frame_words[k];
            end else begin
                word_valid = valid_after;
                word_in    = 8'hEE;
            end
            ready_s = word_ready;
            tick();
            if (word_valid && ready_s && k < 14) k++;
        end
        start      = 1'b0;
        word_valid = 1'b0;
    endtask

    initial begin
        @(negedge clock);
        tick();
        check("reset_config_out", config_out, 112'h0);
        check("reset_loaded", config_loaded, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_ready", word_ready, 1'b0);
        reset = 1'b0;
        tick();

        for (int k = 0; k < 14; k++) frame_words[k] = 8'(k);
        load_frame(1'b0, -1, 1'b0, dc, lk);
        check("t1_done_cycle", dc, 16);
        check("t1_low_byte", config_out[7:0], 8'h00);
        check("t1_high_byte", config_out[111:104], 8'h0D);
        check("t1_image", config_out, 112'h0D0C0B0A09080706050403020100);
        check("t1_loaded", config_loaded, 1'b1);
        check("t1_busy_at_done", busy, 1'b0);
        check("t1_no_leak", lk, 1'b0);
        tick();
        check("t1_done_one_cycle", done, 1'b0);

        load_frame(1'b1, -1, 1'b0, dc, lk);
        check("t2_done_cycle", dc, 29);
        check("t2_image", config_out, 112'h0D0C0B0A09080706050403020100);
        check("t2_no_leak", lk, 1'b0);
        tick();

        for (int k = 0; k < 14; k++) frame_words[k] = 8'hFF;
        load_frame(1'b0, -1, 1'b0, dc, lk);
        check("t3_ones_commit", config_out, {112{1'b1}});
        tick();
        start = 1'b1;
        tick();
        start      = 1'b0;
        word_valid = 1'b1;
        word_in    = 8'h00;
        repeat (7) tick();
        word_valid = 1'b0;
        check("t3_held_ones", config_out, {112{1'b1}});
        check("t3_busy", busy, 1'b1);
        check("t3_no_done", done, 1'b0);
        check("t3_still_loaded", config_loaded, 1'b1);
        tick();
        check("t3_stall_busy", busy, 1'b0 == 1'b0 ? 1'b1 : 1'b0);
        word_valid = 1'b1;
        repeat (3) tick();
        word_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("t4_rst_config_out", config_out, 112'h0);
        check("t4_rst_loaded", config_loaded, 1'b0);
        check("t4_rst_busy", busy, 1'b0);
        check("t4_rst_done", done, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        tick();
        for (int k = 0; k < 14; k++) frame_words[k] = 8'hA5;
        load_frame(1'b0, -1, 1'b0, dc, lk);
        check("t4_a5_done_cycle", dc, 16);
        check("t4_a5_image", config_out, {14{8'hA5}});
        check("t4_a5_loaded", config_loaded, 1'b1);
        tick();

        word_valid = 1'b1;
        word_in    = 8'h77;
        for (int i = 0; i < 3; i++) begin
            check("t5_idle_not_ready", word_ready, 1'b0);
            tick();
        end
        word_valid = 1'b0;
        check("t5_idle_not_busy", busy, 1'b0);
        for (int k = 0; k < 14; k++) frame_words[k] = 8'h10 + 8'(k);
        load_frame(1'b0, 5, 1'b1, dc, lk);
        check("t5_done_cycle", dc, 16);
        check("t5_image", config_out, 112'h1D1C1B1A19181716151413121110);
        tick();

        s_start = 1'b1;
        tick();
        s_start      = 1'b0;
        s_word_valid = 1'b1;
        s_word_in    = 8'h12;
        tick();
        s_word_in = 8'h34;
        tick();
        s_word_in = 8'hAB;
        tick();
        s_word_valid = 1'b0;
        check("t6_commit_cycle_no_done", s_done, 1'b0);
        check("t6_not_yet_visible", s_config_out, 20'h0);
        tick();
        check("t6_done_cycle5", s_done, 1'b1);
        check("t6_image", s_config_out, 20'hB3412);
        check("t6_top_nibble", s_config_out[19:16], 4'hB);
        check("t6_loaded", s_config_loaded, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/switchbox_config_loader.md
SWITCHBOX_CONFIG_LOADER -- requirements
Module: switchbox_config_loader

Interface
REQ-001 Parameter CONFIG_WIDTH, default 112, the width of the parallel configuration word handed to one switch box.
REQ-002 Parameter WORD_WIDTH, default 8, the width of one bitstream word accepted per handshake.
REQ-003 Port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  single-cycle request to begin loading a new frame.
REQ-006 Port word_in  input  WORD_WIDTH  bitstream word.
REQ-007 Port word_valid  input  1  word_in carries a valid word.
REQ-008 Port word_ready  output  1  the loader accepts word_in in this cycle.
REQ-009 Port config_out  output  CONFIG_WIDTH  committed configuration, driven directly to the switch box config_in.
REQ-010 Port config_loaded  output  1  config_out holds a committed frame.
REQ-011 Port busy  output  1  a frame load is in progress.
REQ-012 Port done  output  1  one-cycle pulse on each commit.

Function
REQ-013 The block SHALL compute NUM_WORDS = ceil(CONFIG_WIDTH / WORD_WIDTH), which is 14 at the defaults.
REQ-014 The block SHALL implement three states, IDLE, LOAD and COMMIT, with IDLE as the reset state.
REQ-015 IDLE -> LOAD SHALL occur on a rising edge with start=1; the edge also clears the word counter.
REQ-016 word_ready SHALL be 1 exactly when the state is LOAD; a word transfers on an edge with word_valid=1 and word_ready=1.
REQ-017 The word accepted at counter value k SHALL be written to shadow bits [k*WORD_WIDTH +: WORD_WIDTH]; bits at index CONFIG_WIDTH or above SHALL be discarded.
REQ-018 The counter SHALL increment by one per transfer; the transfer at k = NUM_WORDS-1 SHALL move the state to COMMIT, and the counter never wraps past NUM_WORDS-1.
REQ-019 In COMMIT, the block SHALL copy shadow to config_out and set config_loaded=1 on the next edge, pulse done=1 for the cycle after that edge, and return to IDLE.
REQ-020 config_out SHALL change only on the commit edge; a partially loaded frame SHALL never be visible on config_out.
REQ-021 busy SHALL be 1 in LOAD and COMMIT and 0 in IDLE.
REQ-022 start asserted in LOAD or COMMIT SHALL be ignored, with no restart and no counter clear.
REQ-023 word_valid in IDLE or COMMIT SHALL be ignored, and no data SHALL be captured.
REQ-024 Gaps where word_valid=0 in LOAD SHALL stall the load indefinitely, with no timeout.
REQ-025 start in IDLE while config_loaded=1 SHALL load a new frame; the old config_out SHALL be held until the new commit.
REQ-026 Minimum latency from start to the done pulse SHALL be NUM_WORDS+2 cycles when word_valid is held high.

Reset
REQ-027 Asserting reset SHALL immediately force: state=IDLE, counter=0, shadow=0, config_out=0 (all switch box muxes select input 0), config_loaded=0, busy=0, done=0.
REQ-028 Reset during LOAD or COMMIT SHALL abandon the frame; no partial or stale data SHALL reach config_out.
REQ-029 Deassertion SHALL take effect from the first rising edge after reset falls; no other output SHALL change before that edge.

Structure
REQ-030 The shared package SHALL hold the state enumeration (IDLE, LOAD, COMMIT) and the default constants SB_CONFIG_WIDTH=112 and CONFIG_WORD_WIDTH=8.
REQ-031 One sub-module, config_shadow_register, SHALL hold the word-addressed shadow and the commit copy; the FSM and counter stay at the top level.
REQ-032 No combinational path SHALL exist from word_valid or start to any output except through state registers.

Verification
REQ-033 Reset, then start and 14 words 0x00..0x0D back-to-back -> done on cycle 16 after start, config_out[7:0]=0x00, [111:104]=0x0D, config_loaded=1.
REQ-034 Frame with word_valid toggling every other cycle -> the same committed data; done on cycle 29; config_out unchanged before commit.
REQ-035 Committed frame all 0xFF, then a new start and 7 words of 0x00 -> config_out remains all ones, busy=1, done=0.
REQ-036 Reset asserted after the 10th word -> config_out=0 and config_loaded=0 immediately; a following full frame of 0xA5 commits correctly.
REQ-037 start pulsed again mid-LOAD at word 5, plus word_valid asserted while IDLE -> no restart, idle words not captured, done after word 14.
REQ-038 CONFIG_WIDTH=20 and WORD_WIDTH=8 -> NUM_WORDS=3, the upper 4 bits of the third word discarded, config_out[19:16] equal to the low nibble of the third word.
